dm_arbiter: RTL and testbench

Round-robin, pipelined arbiter that lets `core_count` processor cores share one single-port synchronous data memory. It replaces the direct point-to-point AR/DR/mem_write hookup between one core and data memory in the multi-core build. It accepts at most one request per cycle and forwards it to memory through registered outputs. Read data is routed back to the requesting core with a fixed latency.

---
 rtl/dm_arbiter.sv | 118 +++++++++++
 tb/tb_dm_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory among several cores.
// Accepts one request per cycle, registers it onto the memory port and routes read data back.
module dm_arbiter #(
  parameter int unsigned reg_width   = 12,
  parameter int unsigned addr_width  = 12,
  parameter int unsigned core_count  = 4,
  parameter int unsigned mem_latency = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            req_valid,
  input  logic [core_count-1:0]            req_write,
  input  logic [core_count*addr_width-1:0] req_addr,
  input  logic [core_count*reg_width-1:0]  req_wdata,
  output logic [core_count-1:0]            req_ready,
  output logic [core_count-1:0]            rsp_valid,
  output logic [reg_width-1:0]             rsp_rdata,
  output logic [addr_width-1:0]            mem_addr,
  output logic [reg_width-1:0]             mem_wdata,
  output logic                             mem_write,
  input  logic [reg_width-1:0]             mem_rdata,
  output logic [15:0]                      conflict_count
);

  localparam int unsigned PtrW  = (core_count > 1) ? $clog2(core_count) : 1;
  localparam int unsigned Depth = mem_latency + 1;

  logic [PtrW-1:0]             ptr_q, ptr_d;
  logic                        grant_vld;
  logic [PtrW-1:0]             grant_idx;
  logic                        accept;
  logic                        sel_write;
  logic [addr_width-1:0]       sel_addr;
  logic [reg_width-1:0]        sel_wdata;
  logic                        multi_req;
  int unsigned                 cand;
  logic [PtrW-1:0]             cand_idx;

  logic [addr_width-1:0]       mem_addr_q;
  logic [reg_width-1:0]        mem_wdata_q;
  logic                        mem_write_q;
  logic [core_count-1:0]       rsp_valid_q;
  logic [reg_width-1:0]        rsp_rdata_q;
  logic [15:0]                 conflict_q;
  logic [Depth-1:0]            tag_rd_q;
  logic [Depth-1:0][PtrW-1:0]  tag_idx_q;

  // First valid core at or after ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned j = 0; j < core_count; j++) begin
      cand = 32'(ptr_q) + j;
      if (cand >= core_count) begin
        cand = cand - core_count;
      end
      cand_idx = PtrW'(cand);
      if (!grant_vld && req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    accept    = grant_vld && !reset;
    req_ready = accept ? (core_count'(1) << grant_idx) : '0;
    sel_write = req_write[grant_idx];
    sel_addr  = req_addr[grant_idx*addr_width +: addr_width];
    sel_wdata = req_wdata[grant_idx*reg_width +: reg_width];
    multi_req = $countones(req_valid) >= 2;
    ptr_d     = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == PtrW'(core_count - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      conflict_q  <= '0;
      tag_rd_q    <= '0;
      tag_idx_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      mem_write_q <= accept && sel_write;
      tag_rd_q    <= {tag_rd_q[Depth-2:0], accept && !sel_write};
      tag_idx_q   <= {tag_idx_q[Depth-2:0], grant_idx};
      rsp_valid_q <= tag_rd_q[Depth-1] ? (core_count'(1) << tag_idx_q[Depth-1]) : '0;
      if (tag_rd_q[Depth-1]) begin
        rsp_rdata_q <= mem_rdata;
      end
      if (multi_req && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  // A write registered just before reset must not reach memory during the reset cycle.
  assign mem_write      = mem_write_q && !reset;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a 4-core/latency-1 instance (directed + random) and an
// 8-core/latency-2 instance (random), each checked by a reference-model scoreboard.
module tb_dm_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;

  typedef struct {
    int             core;
    logic [DW-1:0]  data;
    longint         due;
  } exp_t;

  logic   clk = 1'b0;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]      rv    [2];
  logic [7:0]      rw    [2];
  logic [8*AW-1:0] ra    [2];
  logic [8*DW-1:0] rd    [2];
  logic            rst   [2];
  logic [7:0]      rdy8  [2];
  logic [7:0]      rspv8 [2];
  logic [DW-1:0]   rdata [2];
  logic [AW-1:0]   maddr [2];
  logic [DW-1:0]   mwd   [2];
  logic            mwr   [2];
  logic [15:0]     cc    [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int NC  = (g == 0) ? 4 : 8;
    localparam int LAT = (g == 0) ? 1 : 2;

    logic [NC-1:0] ready, rspv;
    logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [15:0]   ccount;

    dm_arbiter #(
      .reg_width  (DW),
      .addr_width (AW),
      .core_count (NC),
      .mem_latency(LAT)
    ) u_dut (
      .clk           (clk),
      .reset         (rst[g]),
      .req_valid     (rv[g][NC-1:0]),
      .req_write     (rw[g][NC-1:0]),
      .req_addr      (ra[g][NC*AW-1:0]),
      .req_wdata     (rd[g][NC*DW-1:0]),
      .req_ready     (ready),
      .rsp_valid     (rspv),
      .rsp_rdata     (rsp_rdata),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_write     (mem_write),
      .mem_rdata     (mem_rdata),
      .conflict_count(ccount)
    );

    assign rdy8[g]  = 8'(ready);
    assign rspv8[g] = 8'(rspv);
    assign rdata[g] = rsp_rdata;
    assign maddr[g] = mem_addr;
    assign mwd[g]   = mem_wdata;
    assign mwr[g]   = mem_write;
    assign cc[g]    = ccount;

    // Synchronous memory device with LAT cycles from sampled address to data.
    logic [DW-1:0] ram     [256];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 256; i++) ram[i] <= '0;
      end else if (mem_write) begin
        ram[mem_addr[7:0]] <= mem_wdata;
      end
      rd_pipe[0] <= ram[mem_addr[7:0]];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference model: round-robin over the requests, memory updated in acceptance order.
    bit            minit;
    int            ptr_m;
    logic [DW-1:0] model_mem [256];
    exp_t          exp_q [$];
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_write;
    logic          pend_w;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic [15:0]   e_cc;
    int            wait_cnt [NC];

    always @(negedge clk) begin
      int   k;
      int   nv;
      exp_t e;
      if (!minit) begin
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        minit = 1'b1;
      end
      if (rst[g]) begin
        check("ready_in_reset", 64'(ready), 64'd0);
        check("mem_write_in_reset", 64'(mem_write), 64'd0);
        ptr_m = 0;
        exp_q.delete();
        e_addr  = '0;
        e_wdata = '0;
        e_write = 1'b0;
        pend_w  = 1'b0;
        e_cc    = '0;
        for (int i = 0; i < NC; i++) wait_cnt[i] = 0;
      end else begin
        if (pend_w) model_mem[pend_a[7:0]] = pend_d;
        pend_w = 1'b0;
        if (rspv != '0) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rspv), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_core", 64'(rspv), 64'd1 << e.core);
            check("rsp_data", 64'(rsp_rdata), 64'(e.data));
            check("rsp_cycle", 64'(cyc), 64'(e.due));
          end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          check("rsp_missing", 64'(rspv), 64'd1 << e.core);
        end
        check("mem_addr", 64'(mem_addr), 64'(e_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        check("mem_write", 64'(mem_write), 64'(e_write));
        check("conflict_count", 64'(ccount), 64'(e_cc));
        nv = $countones(rv[g][NC-1:0]);
        if (nv >= 2 && e_cc != 16'hFFFF) e_cc = e_cc + 16'd1;
        k = -1;
        for (int j = 0; j < NC; j++) begin
          if (k < 0 && rv[g][(ptr_m + j) % NC]) k = (ptr_m + j) % NC;
        end
        check("req_ready", 64'(ready), (k < 0) ? 64'd0 : (64'd1 << k));
        for (int i = 0; i < NC; i++) begin
          if (!rv[g][i]) wait_cnt[i] = 0;
          else if (i != k) wait_cnt[i]++;
        end
        e_write = 1'b0;
        if (k >= 0) begin
          check("wait_bound", 64'(wait_cnt[k] <= NC - 1), 64'd1);
          wait_cnt[k] = 0;
          e_addr  = ra[g][k*AW +: AW];
          e_wdata = rd[g][k*DW +: DW];
          e_write = rw[g][k];
          if (rw[g][k]) begin
            pend_w = 1'b1;
            pend_a = e_addr;
            pend_d = e_wdata;
          end else begin
            exp_q.push_back('{k, model_mem[e_addr[7:0]], cyc + 2 + LAT});
          end
          ptr_m = (k + 1) % NC;
        end
      end
    end
  end

  task automatic set_req(input int g, input int core, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    rv[g][core]           = 1'b1;
    rw[g][core]           = wr;
    ra[g][core*AW +: AW]  = a;
    rd[g][core*DW +: DW]  = d;
  endtask

  // Returns at the negedge of the accept cycle.
  task automatic wait_accept(input int g, input int core);
    int n = 0;
    @(negedge clk);
    while (!rdy8[g][core] && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!rdy8[g][core]) check("accept_timeout", 64'(rdy8[g][core]), 64'd1);
  endtask

  task automatic drop(input int g, input int core);
    @(posedge clk);
    #1;
    rv[g][core] = 1'b0;
  endtask

  task automatic rand_phase(input int g, input int nc, input int cycles);
    logic [7:0] acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = rv[g] & rdy8[g];
      @(posedge clk);
      #1;
      for (int i = 0; i < nc; i++) begin
        if (!rv[g][i] || acc[i]) begin
          if ($urandom_range(0, 99) < 55)
            set_req(g, i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
          else
            rv[g][i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    rv[g] = '0;
  endtask

  task automatic directed_a();
    int            nwr;
    logic [DW-1:0] got;
    // Single read by core 2 after core 0 preloads the location.
    set_req(0, 0, 1'b1, 12'h0A5, 12'h3C7);
    wait_accept(0, 0);
    drop(0, 0);
    set_req(0, 2, 1'b0, 12'h0A5, 12'h000);
    wait_accept(0, 2);
    check("single_ready", 64'(rdy8[0]), 64'h04);
    drop(0, 2);
    @(negedge clk);
    check("single_mem_addr", 64'(maddr[0]), 64'h0A5);
    check("single_mem_write", 64'(mwr[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("single_rsp_valid", 64'(rspv8[0]), 64'h04);
    check("single_rsp_data", 64'(rdata[0]), 64'h3C7);

    // Full contention from reset.
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    for (int i = 0; i < 4; i++) set_req(0, i, 1'b0, AW'(12'h0A0 + i), DW'(i));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("contention_grant", 64'(rdy8[0]), 64'd1 << k);
      @(posedge clk);
      #1;
      rv[0][k] = 1'b0;
    end
    @(negedge clk);
    check("contention_conflicts", 64'(cc[0]), 64'd3);

    // Write then read of the same address, back to back.
    @(posedge clk);
    #1;
    set_req(0, 1, 1'b1, 12'h010, 12'h123);
    set_req(0, 3, 1'b0, 12'h010, 12'h000);
    @(negedge clk);
    check("wtr_grant1", 64'(rdy8[0]), 64'h02);
    @(posedge clk);
    #1;
    rv[0][1] = 1'b0;
    @(negedge clk);
    check("wtr_grant3", 64'(rdy8[0]), 64'h08);
    nwr = int'(mwr[0]);
    got = '0;
    @(posedge clk);
    #1;
    rv[0][3] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      nwr += int'(mwr[0]);
      if (rspv8[0][3]) got = rdata[0];
    end
    check("wtr_write_pulses", 64'(nwr), 64'd1);
    check("wtr_read_data", 64'(got), 64'h123);

    // Reset one cycle after a read is accepted.
    @(posedge clk);
    #1;
    set_req(0, 2, 1'b0, 12'h010, 12'hABC);
    @(negedge clk);
    check("rif_accept", 64'(rdy8[0]), 64'h04);
    @(posedge clk);
    #1;
    rv[0][2] = 1'b0;
    rst[0]   = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("rif_mem_addr", 64'(maddr[0]), 64'd0);
    check("rif_mem_wdata", 64'(mwd[0]), 64'd0);
    check("rif_mem_write", 64'(mwr[0]), 64'd0);
    check("rif_rsp_rdata", 64'(rdata[0]), 64'd0);
    check("rif_conflicts", 64'(cc[0]), 64'd0);
    repeat (10) begin
      @(negedge clk);
      check("rif_no_rsp", 64'(rspv8[0]), 64'd0);
    end

    // A write whose memory cycle coincides with reset never lands.
    @(posedge clk);
    #1;
    set_req(0, 1, 1'b1, 12'h020, 12'h555);
    @(negedge clk);
    check("suppress_accept", 64'(rdy8[0]), 64'h02);
    @(posedge clk);
    #1;
    rv[0][1] = 1'b0;
    rst[0]   = 1'b1;
    @(negedge clk);
    check("suppress_mem_write", 64'(mwr[0]), 64'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    set_req(0, 0, 1'b0, 12'h020, 12'h000);
    set_req(0, 3, 1'b0, 12'h0A5, 12'h000);
    @(negedge clk);
    check("post_reset_grant_core0", 64'(rdy8[0]), 64'h01);
    @(posedge clk);
    #1;
    rv[0][0] = 1'b0;
    @(negedge clk);
    check("post_reset_grant_core3", 64'(rdy8[0]), 64'h08);
    @(posedge clk);
    #1;
    rv[0][3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("suppress_rsp_valid", 64'(rspv8[0]), 64'h01);
    check("suppress_rsp_data", 64'(rdata[0]), 64'd0);

    // Two requesters held forever: counter saturates.
    @(posedge clk);
    #1;
    set_req(0, 0, 1'b0, 12'h001, 12'h000);
    set_req(0, 1, 1'b0, 12'h002, 12'h000);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("sat_ffff", 64'(cc[0]), 64'hFFFF);
    repeat (5) @(negedge clk);
    check("sat_hold", 64'(cc[0]), 64'hFFFF);
    @(posedge clk);
    #1;
    rv[0] = '0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rv[g]  = '0;
      rw[g]  = '0;
      ra[g]  = '0;
      rd[g]  = '0;
      rst[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    fork
      rand_phase(1, 8, 4000);
      begin
        directed_a();
        rand_phase(0, 4, 1500);
      end
    join
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
